// File: rtl/fetch_pc_if.sv
// Fetch PC controller bus: predictor inputs, EX resolution, stall in; PC, redirect and perf counters out.
// Zero-latency wiring only; stall is the sole backpressure, and the master drives it.
interface fetch_pc_if #(
  parameter int XLEN = 32
);
  logic            IF_stall;
  logic            branch_estimation;
  logic [XLEN-1:0] branch_target;
  logic            EX_branch;
  logic            EX_branch_taken;
  logic [XLEN-1:0] EX_branch_target;
  logic            EX_jump;
  logic [XLEN-1:0] EX_jump_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            flush;
  logic            mispredict;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output IF_stall, branch_estimation, branch_target,
           EX_branch, EX_branch_taken, EX_branch_target,
           EX_jump, EX_jump_target,
    input  pc, next_pc, flush, mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  IF_stall, branch_estimation, branch_target,
           EX_branch, EX_branch_taken, EX_branch_target,
           EX_jump, EX_jump_target,
    output pc, next_pc, flush, mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/fetch_pc_controller.sv
// Owns the fetch PC, shadows each prediction through ID/EX and redirects on mispredict/jump (2-cycle penalty).
// Stall holds PC and the ID slot and bubbles EX; a redirect overrides the stall.
module fetch_pc_controller #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_pc_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] fallthrough;
  } slot_t;

  slot_t           s_id_q, s_id_d;
  slot_t           s_ex_q, s_ex_d;
  slot_t           if_fill;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic [31:0]     branch_count_q, branch_count_d;
  logic [31:0]     mispredict_count_q, mispredict_count_d;
  logic            br_vld;
  logic            jmp_vld;
  logic            dir_wrong;
  logic            tgt_wrong;
  logic            br_mis;
  logic            redirect;

  always_comb begin
    pc_plus4 = pc_q + XLEN'(4);

    if_fill.valid       = 1'b1;
    if_fill.pred_taken  = bus.branch_estimation;
    if_fill.pred_target = bus.branch_target;
    if_fill.fallthrough = pc_plus4;

    // An invalid EX slot (bubble or flushed) makes every EX_* input a don't-care.
    br_vld    = s_ex_q.valid & bus.EX_branch;
    jmp_vld   = s_ex_q.valid & bus.EX_jump;
    dir_wrong = s_ex_q.pred_taken != bus.EX_branch_taken;
    tgt_wrong = s_ex_q.pred_taken & bus.EX_branch_taken &
                (s_ex_q.pred_target != bus.EX_branch_target);
    br_mis    = br_vld & (dir_wrong | tgt_wrong);
    redirect  = jmp_vld | br_mis;

    if (jmp_vld) begin
      redirect_target = bus.EX_jump_target;
    end else if (bus.EX_branch_taken) begin
      redirect_target = bus.EX_branch_target;
    end else begin
      redirect_target = s_ex_q.fallthrough;
    end

    if (redirect) begin
      pc_d = redirect_target;
    end else if (bus.IF_stall) begin
      pc_d = pc_q;
    end else if (bus.branch_estimation) begin
      pc_d = bus.branch_target;
    end else begin
      pc_d = pc_plus4;
    end

    if (redirect) begin
      s_id_d = '0;
      s_ex_d = '0;
    end else if (bus.IF_stall) begin
      s_id_d = s_id_q;
      s_ex_d = '0;
    end else begin
      s_id_d = if_fill;
      s_ex_d = s_id_q;
    end

    // A simultaneous branch+jump still counts the branch even though the jump steers.
    branch_count_d     = branch_count_q + (br_vld ? 32'd1 : 32'd0);
    mispredict_count_d = mispredict_count_q + (br_mis ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q               <= RESET_VECTOR;
      s_id_q             <= '0;
      s_ex_q             <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      pc_q               <= pc_d;
      s_id_q             <= s_id_d;
      s_ex_q             <= s_ex_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.next_pc          = pc_d;
  assign bus.flush            = redirect;
  assign bus.mispredict       = br_mis;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Directed cycle table for fetch_pc_controller plus a reset-versus-redirect sequence.
module tb_fetch_pc_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_pc_if #(.XLEN(32)) bus ();

  fetch_pc_controller #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        est;
    logic [31:0] tgt;
    logic        exb;
    logic        ext;
    logic [31:0] exbt;
    logic        exj;
    logic [31:0] exjt;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_fl;
    logic        e_mp;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic stall, input logic est, input logic [31:0] tgt,
                              input logic exb, input logic ext, input logic [31:0] exbt,
                              input logic exj, input logic [31:0] exjt,
                              input logic [31:0] e_pc, input logic [31:0] e_npc,
                              input logic e_fl, input logic e_mp,
                              input logic [31:0] e_bc, input logic [31:0] e_mc);
    vec_t v;
    v.stall = stall; v.est = est; v.tgt = tgt;
    v.exb = exb; v.ext = ext; v.exbt = exbt; v.exj = exj; v.exjt = exjt;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_fl = e_fl; v.e_mp = e_mp;
    v.e_bc = e_bc; v.e_mc = e_mc;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.IF_stall          = v.stall;
    bus.branch_estimation = v.est;
    bus.branch_target     = v.tgt;
    bus.EX_branch         = v.exb;
    bus.EX_branch_taken   = v.ext;
    bus.EX_branch_target  = v.exbt;
    bus.EX_jump           = v.exj;
    bus.EX_jump_target    = v.exjt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    idle = '{default: '0};

    //   stall est tgt           exb ext exbt          exj exjt          pc            next_pc       fl mp bc    mc
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h100,      32'h104,      0, 0, 32'd0, 32'd0);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h104,      32'h108,      0, 0, 32'd0, 32'd0);
    add(0, 1, 32'h200,      0, 0, 32'h0,   0, 32'h0,   32'h108,      32'h200,      0, 0, 32'd0, 32'd0);
    add(0, 1, 32'h180,      0, 0, 32'h0,   0, 32'h0,   32'h200,      32'h180,      0, 0, 32'd0, 32'd0);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h180,      32'h184,      0, 0, 32'd0, 32'd0);
    add(0, 0, 32'h0,        1, 1, 32'h180, 0, 32'h0,   32'h184,      32'h188,      0, 0, 32'd0, 32'd0);
    add(0, 1, 32'h300,      0, 0, 32'h0,   0, 32'h0,   32'h188,      32'h300,      0, 0, 32'd1, 32'd0);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h300,      32'h304,      0, 0, 32'd1, 32'd0);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h304,      32'h308,      0, 0, 32'd1, 32'd0);
    add(0, 0, 32'h0,        1, 1, 32'h340, 0, 32'h0,   32'h308,      32'h340,      1, 1, 32'd1, 32'd0);
    add(0, 0, 32'h0,        1, 1, 32'h999, 0, 32'h0,   32'h340,      32'h344,      0, 0, 32'd2, 32'd1);
    add(0, 1, 32'h400,      0, 0, 32'h0,   1, 32'h900, 32'h344,      32'h400,      0, 0, 32'd2, 32'd1);
    add(0, 1, 32'h3F0,      0, 0, 32'h0,   0, 32'h0,   32'h400,      32'h3F0,      0, 0, 32'd2, 32'd1);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h3F0,      32'h3F4,      0, 0, 32'd2, 32'd1);
    add(0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h3F4,      32'h404,      1, 1, 32'd2, 32'd1);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h404,      32'h408,      0, 0, 32'd3, 32'd2);
    add(1, 1, 32'h999,      0, 0, 32'h0,   0, 32'h0,   32'h408,      32'h408,      0, 0, 32'd3, 32'd2);
    add(0, 0, 32'h0,        1, 1, 32'h500, 0, 32'h0,   32'h408,      32'h40C,      0, 0, 32'd3, 32'd2);
    add(0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h40C,      32'h410,      0, 0, 32'd3, 32'd2);
    add(1, 0, 32'h0,        1, 1, 32'h600, 0, 32'h0,   32'h410,      32'h600,      1, 1, 32'd4, 32'd2);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h600,      32'h604,      0, 0, 32'd5, 32'd3);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h604,      32'h608,      0, 0, 32'd5, 32'd3);
    add(0, 1, 32'h777,      0, 0, 32'h0,   1, 32'h800, 32'h608,      32'h800,      1, 0, 32'd5, 32'd3);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h800,      32'h804,      0, 0, 32'd5, 32'd3);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h804,      32'h808,      0, 0, 32'd5, 32'd3);
    add(0, 0, 32'h0,        1, 0, 32'h0,   1, 32'hA00, 32'h808,      32'hA00,      1, 0, 32'd5, 32'd3);
    add(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,   0, 32'h0,   32'hA00,      32'hFFFFFFFC, 0, 0, 32'd6, 32'd3);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'hFFFFFFFC, 32'h0,        0, 0, 32'd6, 32'd3);
    add(0, 0, 32'h0,        1, 1, 32'hB00, 0, 32'h0,   32'h0,        32'hB00,      1, 1, 32'd6, 32'd3);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'hB00,      32'hB04,      0, 0, 32'd7, 32'd4);
    add(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'hB04,      32'hB08,      0, 0, 32'd7, 32'd4);

    reset = 1'b1;
    drive(idle);
    @(posedge clk);
    #1;
    chk("reset_pc",      bus.pc,               32'h100);
    chk("reset_next_pc", bus.next_pc,          32'h104);
    chk("reset_bc",      bus.branch_count,     32'd0);
    chk("reset_mc",      bus.mispredict_count, 32'd0);
    chk("reset_flush",   {31'd0, bus.flush},   32'd0);
    @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vq[i]);
      #2;
      chk($sformatf("row%0d_pc", i),      bus.pc,                 vq[i].e_pc);
      chk($sformatf("row%0d_next_pc", i), bus.next_pc,            vq[i].e_npc);
      chk($sformatf("row%0d_flush", i),   {31'd0, bus.flush},      {31'd0, vq[i].e_fl});
      chk($sformatf("row%0d_misp", i),    {31'd0, bus.mispredict}, {31'd0, vq[i].e_mp});
      chk($sformatf("row%0d_bc", i),      bus.branch_count,       vq[i].e_bc);
      chk($sformatf("row%0d_mc", i),      bus.mispredict_count,   vq[i].e_mc);
    end

    // The B00 fetch now sits in EX; a jump there must lose to a same-cycle reset.
    @(negedge clk);
    drive(idle);
    bus.EX_jump        = 1'b1;
    bus.EX_jump_target = 32'hC00;
    reset              = 1'b1;
    #2;
    chk("rst_vs_jump_flush_pre", {31'd0, bus.flush}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_vs_jump_pc",    bus.pc,               32'h100);
    chk("rst_vs_jump_bc",    bus.branch_count,     32'd0);
    chk("rst_vs_jump_mc",    bus.mispredict_count, 32'd0);
    chk("rst_vs_jump_flush", {31'd0, bus.flush},   32'd0);

    @(negedge clk);
    reset = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    chk("post_reset_pc", bus.pc, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_controller.md
# fetch_pc_controller

Fetch-stage PC controller that consumes the branch predictor's IF-stage outputs (`branch_estimation`, `branch_target`) and owns the architectural fetch PC. It carries each fetched instruction's prediction alongside the IF/ID and ID/EX pipeline registers, compares it with the outcome resolved in EX, and on a misprediction or jump redirects fetch and flushes the wrong-path instructions. It also keeps branch and mispredict performance counters.

## Interface
- `XLEN`, 32, datapath width
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the clock edge it is high
- `IF_stall`  in  1  hazard stall; holds the PC and the IF/ID slot, and inserts a bubble into the ID/EX slot
- `branch_estimation`  in  1  predictor's taken guess for the instruction currently at `pc`
- `branch_target`  in  XLEN  predicted target, used only when `branch_estimation`=1
- `EX_branch`  in  1  instruction in EX is a conditional branch
- `EX_branch_taken`  in  1  resolved branch outcome
- `EX_branch_target`  in  XLEN  resolved taken target (pc+imm)
- `EX_jump`  in  1  instruction in EX is JAL/JALR
- `EX_jump_target`  in  XLEN  resolved jump target
- `pc`  out  XLEN  current fetch PC (registered)
- `next_pc`  out  XLEN  combinational value `pc` takes at the next edge
- `flush`  out  1  combinational; kill the IF/ID and ID/EX contents at the next edge
- `mispredict`  out  1  combinational; EX branch was mispredicted this cycle
- `branch_count`  out  32  resolved branches, wraps modulo 2^32
- `mispredict_count`  out  32  mispredicted branches, wraps modulo 2^32

## Operation
- Shadow slots `S_ID` and `S_EX`, each holding {valid, pred_taken, pred_target, fallthrough}.
  - Fill source is IF: valid=1, pred_taken=`branch_estimation`, pred_target=`branch_target`, fallthrough=`pc`+4 (truncated to XLEN).
- Branch resolution, qualified by `S_EX.valid` && `EX_branch`:
  - A mispredict is `pred_taken`≠`EX_branch_taken`.
  - A mispredict is also `pred_taken`&&`EX_branch_taken`&&`pred_target`≠`EX_branch_target`.
- Jump: `S_EX.valid` && `EX_jump` is an unconditional redirect. It is not counted as a mispredict.
- The redirect target is chosen in this order:
  - jump → `EX_jump_target`
  - branch mispredict with actual taken → `EX_branch_target`
  - branch mispredict with actual not taken → `S_EX.fallthrough`
- `flush` = redirect. `mispredict` = branch mispredict only.
- `next_pc` priority, highest first:
  - redirect target
  - `IF_stall` → `pc`
  - `branch_estimation` → `branch_target`
  - `pc`+4
- Slot update with no flush:
  - if `IF_stall`: `S_EX`←bubble (valid=0) and `S_ID` holds
  - otherwise: `S_EX`←`S_ID` and `S_ID`←IF fill
- Slot update with flush: `S_ID` and `S_EX` both become invalid. Flush overrides stall.
- Counters:
  - `branch_count`+1 per qualified branch resolution.
  - `mispredict_count`+1 when `mispredict`=1.
- With `S_EX.valid`=0, `EX_*` inputs are ignored: no flush, no count.
- `EX_branch` and `EX_jump` both high is illegal. If it happens, jump wins and the branch is still counted.

## Timing
- Reset values:
  - `pc`=`RESET_VECTOR`
  - both slots invalid
  - `branch_count`=`mispredict_count`=0
  - `flush`=`mispredict`=0
  - `next_pc`=`RESET_VECTOR`+4 when there is no stall or estimate
- Reset has priority over everything, including a redirect in the same cycle.
- Prediction to PC: `branch_estimation`/`branch_target` seen in cycle N set `pc` at edge N+1. That is zero-bubble taken-branch fetch.
- Branch fetched with `pc` at cycle N, no stalls: it reaches EX in N+2. Flush and redirect occur there, and the correct-path `pc` appears at N+3.
- Mispredict penalty: 2 cycles.
- Counters update at the edge ending the resolution cycle.
- Stall in the resolution cycle: the redirect still happens and `flush` is still asserted.
- `pc`+4 and the counters wrap silently at their width.

## Test plan
- Reset: `RESET_VECTOR`=0x100, hold `reset` 2 cycles, then release with no estimates → `pc` goes 0x100, 0x104, 0x108; counters 0; `flush`=0.
- Correct taken prediction:
  - stimulus: at `pc`=0x200 drive `branch_estimation`=1, `branch_target`=0x180; two cycles later `EX_branch`=1, taken, target=0x180
  - response: next `pc`=0x180; `flush`=0; `branch_count`=1, `mispredict_count`=0
- Predicted not-taken, actually taken:
  - stimulus: at `pc`=0x300, estimate 0; in EX, taken with target 0x340
  - response: `flush`=`mispredict`=1 for one cycle; `pc`=0x340 next; both counters 1
- Predicted taken, actually not taken:
  - stimulus: at `pc`=0x400, estimate 1 with target 0x3F0; EX resolves not-taken
  - response: redirect to 0x404; `mispredict_count`+1
- Stall interaction:
  - stimulus: branch in ID when `IF_stall`=1 for 1 cycle
  - response: `pc` held; EX sees a bubble (no count); the branch resolves one cycle later
  - stimulus: stall asserted in the same cycle as an EX mispredict
  - response: the redirect still occurs
- JAL in EX with target 0x800 → `flush`=1, `pc`=0x800, `mispredict`=0, counters unchanged.
